// File: rtl/scalar_wb_demux_16.sv
// Scalar write-back demux: buffers {index,data} write requests in an in-order FIFO
// and retires them into the 16 scalar registers Q00..Q15 that feed the read mux.
module scalar_wb_demux_16 #(
  parameter int N     = 4,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [4:0]   in_addr,
  input  logic [N-1:0] in_data,
  input  logic         wr_hold,
  output logic [N-1:0] Q00,
  output logic [N-1:0] Q01,
  output logic [N-1:0] Q02,
  output logic [N-1:0] Q03,
  output logic [N-1:0] Q04,
  output logic [N-1:0] Q05,
  output logic [N-1:0] Q06,
  output logic [N-1:0] Q07,
  output logic [N-1:0] Q08,
  output logic [N-1:0] Q09,
  output logic [N-1:0] Q10,
  output logic [N-1:0] Q11,
  output logic [N-1:0] Q12,
  output logic [N-1:0] Q13,
  output logic [N-1:0] Q14,
  output logic [N-1:0] Q15,
  output logic [15:0]  pend,
  output logic         err_addr,
  output logic         idle
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

  logic [4:0]       addr_mem [DEPTH];
  logic [N-1:0]     data_mem [DEPTH];
  logic [DEPTH-1:0] vld;
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic [N-1:0]     regs [16];

  logic             push;
  logic             pop;
  logic [4:0]       head_addr;
  logic [N-1:0]     head_data;

  // A retire in the same cycle never frees a slot for a push: ready looks at count only.
  assign in_ready  = (count < FULL);
  assign idle      = (count == '0);
  assign push      = in_valid && in_ready;
  assign pop       = (count != '0) && !wr_hold;
  assign head_addr = addr_mem[rd_ptr];
  assign head_data = data_mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      vld    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        addr_mem[i] <= '0;
        data_mem[i] <= '0;
      end
    end else begin
      if (pop) begin
        vld[rd_ptr] <= 1'b0;
        rd_ptr      <= (rd_ptr == LAST) ? '0 : rd_ptr + 1'b1;
      end
      if (push) begin
        addr_mem[wr_ptr] <= in_addr;
        data_mem[wr_ptr] <= in_data;
        vld[wr_ptr]      <= 1'b1;
        wr_ptr           <= (wr_ptr == LAST) ? '0 : wr_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Head entry commits to its register, or raises a one-cycle error if out of range.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_addr <= 1'b0;
      for (int k = 0; k < 16; k++) regs[k] <= '0;
    end else begin
      err_addr <= 1'b0;
      if (pop) begin
        if (!head_addr[4]) regs[head_addr[3:0]] <= head_data;
        else               err_addr <= 1'b1;
      end
    end
  end

  always_comb begin
    pend = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (vld[i] && !addr_mem[i][4]) pend[addr_mem[i][3:0]] = 1'b1;
    end
  end

  assign Q00 = regs[0];
  assign Q01 = regs[1];
  assign Q02 = regs[2];
  assign Q03 = regs[3];
  assign Q04 = regs[4];
  assign Q05 = regs[5];
  assign Q06 = regs[6];
  assign Q07 = regs[7];
  assign Q08 = regs[8];
  assign Q09 = regs[9];
  assign Q10 = regs[10];
  assign Q11 = regs[11];
  assign Q12 = regs[12];
  assign Q13 = regs[13];
  assign Q14 = regs[14];
  assign Q15 = regs[15];

endmodule

// File: tb/tb_scalar_wb_demux_16.sv
// Directed self-checking bench for scalar_wb_demux_16 (N=4, DEPTH=2).
module tb_scalar_wb_demux_16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_addr;
  logic [3:0]  in_data;
  logic        wr_hold;
  logic [3:0]  q [16];
  logic [15:0] pend;
  logic        err_addr;
  logic        idle;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  scalar_wb_demux_16 #(.N(4), .DEPTH(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_addr(in_addr), .in_data(in_data),
    .wr_hold(wr_hold),
    .Q00(q[0]),  .Q01(q[1]),  .Q02(q[2]),  .Q03(q[3]),
    .Q04(q[4]),  .Q05(q[5]),  .Q06(q[6]),  .Q07(q[7]),
    .Q08(q[8]),  .Q09(q[9]),  .Q10(q[10]), .Q11(q[11]),
    .Q12(q[12]), .Q13(q[13]), .Q14(q[14]), .Q15(q[15]),
    .pend(pend), .err_addr(err_addr), .idle(idle)
  );

  task automatic checkOutput(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Advance one edge and sample 1ns later, away from the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic v, input logic [4:0] a, input logic [3:0] d,
                               input logic h);
    in_valid = v;
    in_addr  = a;
    in_data  = d;
    wr_hold  = h;
  endtask

  task automatic checkRegs(input string tag, input logic [3:0] exp [16]);
    for (int k = 0; k < 16; k++)
      checkOutput($sformatf("%s_Q%0d", tag, k), {12'h0, q[k]}, {12'h0, exp[k]});
  endtask

  task automatic checkResetState(input string tag);
    logic [3:0] zeros [16];
    for (int k = 0; k < 16; k++) zeros[k] = 4'h0;
    checkRegs(tag, zeros);
    checkOutput({tag, "_ready"}, {15'h0, in_ready}, 16'h1);
    checkOutput({tag, "_pend"},  pend, 16'h0);
    checkOutput({tag, "_idle"},  {15'h0, idle}, 16'h1);
    checkOutput({tag, "_err"},   {15'h0, err_addr}, 16'h0);
  endtask

  logic [3:0] exp_q [16];

  initial begin
    for (int k = 0; k < 16; k++) exp_q[k] = 4'h0;
    rst_n = 1'b0;
    applyStimulus(1'b0, 5'd0, 4'h0, 1'b0);
    #12;
    checkResetState("rst0");
    rst_n = 1'b1;
    step();

    // Single write to register 5
    applyStimulus(1'b1, 5'd5, 4'hA, 1'b0);
    step();
    applyStimulus(1'b0, 5'd0, 4'h0, 1'b0);
    checkOutput("w5_pend", pend, 16'h0020);
    checkOutput("w5_idle", {15'h0, idle}, 16'h0);
    checkOutput("w5_noearly", {12'h0, q[5]}, 16'h0);
    step();
    exp_q[5] = 4'hA;
    checkRegs("w5", exp_q);
    checkOutput("w5_pend_clr", pend, 16'h0);
    checkOutput("w5_idle_after", {15'h0, idle}, 16'h1);

    // Hold retirement, fill FIFO with two writes to register 3
    applyStimulus(1'b1, 5'd3, 4'h1, 1'b1);
    step();
    checkOutput("h_ready1", {15'h0, in_ready}, 16'h1);
    applyStimulus(1'b1, 5'd3, 4'h2, 1'b1);
    step();
    checkOutput("h_ready_full", {15'h0, in_ready}, 16'h0);
    checkOutput("h_pend", pend, 16'h0008);
    applyStimulus(1'b1, 5'd3, 4'h3, 1'b1);
    step();
    checkOutput("h_stall_ready", {15'h0, in_ready}, 16'h0);
    checkOutput("h_stall_q3", {12'h0, q[3]}, 16'h0);
    applyStimulus(1'b0, 5'd0, 4'h0, 1'b0);
    step();
    checkOutput("h_q3_first", {12'h0, q[3]}, 16'h1);
    checkOutput("h_pend_mid", pend, 16'h0008);
    step();
    checkOutput("h_q3_second", {12'h0, q[3]}, 16'h2);
    checkOutput("h_pend_clr", pend, 16'h0);
    checkOutput("h_idle", {15'h0, idle}, 16'h1);
    exp_q[3] = 4'h2;

    // Out-of-range index 18
    applyStimulus(1'b1, 5'b10010, 4'hF, 1'b0);
    step();
    applyStimulus(1'b0, 5'd0, 4'h0, 1'b0);
    checkOutput("oor_pend", pend, 16'h0);
    checkOutput("oor_err_early", {15'h0, err_addr}, 16'h0);
    step();
    checkOutput("oor_err", {15'h0, err_addr}, 16'h1);
    checkOutput("oor_pend2", pend, 16'h0);
    checkRegs("oor", exp_q);
    step();
    checkOutput("oor_err_pulse", {15'h0, err_addr}, 16'h0);

    // Back-to-back stream k -> register k
    for (int k = 0; k < 16; k++) begin
      checkOutput($sformatf("s_ready%0d", k), {15'h0, in_ready}, 16'h1);
      applyStimulus(1'b1, 5'(k), 4'(k), 1'b0);
      step();
      if (k > 0) checkOutput($sformatf("s_commit%0d", k - 1), {12'h0, q[k-1]}, 16'(k - 1));
    end
    applyStimulus(1'b0, 5'd0, 4'h0, 1'b0);
    step();
    for (int k = 0; k < 16; k++) exp_q[k] = 4'(k);
    checkRegs("stream", exp_q);
    checkOutput("s_idle", {15'h0, idle}, 16'h1);

    // Fill under hold, then reset mid-run
    applyStimulus(1'b1, 5'd7, 4'h5, 1'b1);
    step();
    applyStimulus(1'b1, 5'd9, 4'h6, 1'b1);
    step();
    applyStimulus(1'b0, 5'd0, 4'h0, 1'b1);
    checkOutput("f_pend", pend, 16'h0280);
    checkOutput("f_idle", {15'h0, idle}, 16'h0);
    #2;
    rst_n = 1'b0;
    #2;
    checkResetState("rst_mid");
    step();
    rst_n = 1'b1;
    applyStimulus(1'b0, 5'd0, 4'h0, 1'b0);
    step();
    step();
    step();
    checkResetState("post_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
